// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared types and constants for the unified-memory arbiter
package rv_mem_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;
  localparam int LAT_CNT_W = 4;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker; a tie goes to whoever was not granted last
module rr_arb2
  import rv_mem_pkg::*;
(
  input  logic req_if,
  input  logic req_ls,
  input  logic last,
  output logic any,
  output logic pick_ls
);
  assign any = req_if | req_ls;
  assign pick_ls = req_ls & (~req_if | (last == GNT_IF));
endmodule

// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: shares one single-port memory between fetch and load/store, one transaction at a time
module rv_mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_ack,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                grant_ls
);
  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("rv_mem_arbiter: MEM_LATENCY must be in 1..15");
  end
  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("rv_mem_arbiter: DATA_W must be a multiple of 8");
  end
  state_t state, state_n;
  logic [LAT_CNT_W-1:0] cnt;
  logic last, any, pick_ls, grab;
  rr_arb2 u_arb (.req_if(if_req), .req_ls(ls_req), .last(last), .any(any), .pick_ls(pick_ls));
  assign grab = (state == IDLE) && any;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (any ? ISSUE : IDLE) :
              state == ISSUE ? WAIT :
              state == WAIT  ? (cnt == LAT_CNT_W'(1) ? ACK : WAIT) : IDLE;
  end
  // Outputs are all registered off the next state, so no input reaches an output combinationally.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt       <= '0;
      last      <= GNT_LS;
      grant_ls  <= GNT_IF;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      if_ack    <= 1'b0;
      ls_ack    <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      mem_en   <= state_n == ISSUE;
      busy     <= state_n != IDLE;
      cnt      <= state == ISSUE ? LAT_CNT_W'(MEM_LATENCY) : state == WAIT ? cnt - LAT_CNT_W'(1) : cnt;
      if_ack   <= state_n == ACK && grant_ls == GNT_IF;
      ls_ack   <= state_n == ACK && grant_ls == GNT_LS;
      if_rdata <= (state_n == ACK && grant_ls == GNT_IF) ? mem_rdata : '0;
      ls_rdata <= (state_n == ACK && grant_ls == GNT_LS && !mem_we) ? mem_rdata : '0;
      if (grab) begin
        last      <= pick_ls;
        grant_ls  <= pick_ls;
        mem_we    <= pick_ls & ls_we;
        mem_wstrb <= (pick_ls && ls_we) ? ls_wstrb : '0;
        mem_addr  <= pick_ls ? ls_addr : if_addr;
        mem_wdata <= pick_ls ? ls_wdata : '0;
      end
    end
endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb_rv_mem_arbiter: directed vectors plus multi-cycle sequences against latency-1 and latency-3 arbiters
module tb_rv_mem_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  logic if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata, rd_word;
  logic [3:0] ls_wstrb;
  logic if_ack1, ls_ack1, mem_en1, mem_we1, busy1, grant_ls1;
  logic [31:0] if_rdata1, ls_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [3:0] mem_wstrb1;
  logic if_ack3, ls_ack3, mem_en3, mem_we3, busy3, grant_ls3;
  logic [31:0] if_rdata3, ls_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic [3:0] mem_wstrb3;
  int checks = 0;
  int errors = 0;
  rv_mem_arbiter #(.MEM_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack1), .if_rdata(if_rdata1),
    .ls_req(ls_req), .ls_we(ls_we), .ls_wstrb(ls_wstrb), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack1), .ls_rdata(ls_rdata1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_wstrb(mem_wstrb1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1), .grant_ls(grant_ls1)
  );
  rv_mem_arbiter #(.MEM_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack3), .if_rdata(if_rdata3),
    .ls_req(ls_req), .ls_we(ls_we), .ls_wstrb(ls_wstrb), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack3), .ls_rdata(ls_rdata3), .mem_en(mem_en3), .mem_we(mem_we3), .mem_wstrb(mem_wstrb3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3), .grant_ls(grant_ls3)
  );
  // Memory models: read data is only meaningful exactly MEM_LATENCY cycles after mem_en, garbage otherwise.
  logic v1;
  logic [2:0] v3;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      v1 <= 1'b0;
      v3 <= 3'b0;
    end else begin
      v1 <= mem_en1;
      v3 <= {v3[1:0], mem_en3};
    end
  assign mem_rdata1 = v1 ? rd_word : 32'hBAD0_BAD0;
  assign mem_rdata3 = v3[2] ? rd_word : 32'hBAD0_BAD0;

  typedef struct {
    logic ir; logic [31:0] ia;
    logic lr; logic lw; logic [3:0] ls; logic [31:0] la; logic [31:0] ld; logic [31:0] rw;
    logic en; logic we; logic [3:0] st; logic [31:0] ma; logic [31:0] md;
    logic ik; logic [31:0] ird; logic lk; logic [31:0] lrd; logic bz; logic gl;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_wstrb = 4'h0;
    if_addr = 32'h0; ls_addr = 32'h0; ls_wdata = 32'h0; rd_word = 32'h0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  int n, prev, e1, e2, na, cons;
  logic pk;
  initial begin
    tv[0] = '{1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0010_0093, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    tv[1] = '{1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0010_0093, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0};
    tv[2] = '{1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0010_0093, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0};
    tv[3] = '{1'b0, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0010_0093, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0010_0093, 1'b0, 32'h0, 1'b1, 1'b0};
    tv[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0010_0093, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    tv[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    tv[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1};
    tv[7] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1};
    tv[8] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1};
    tv[9] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};

    // Vector table on the latency-1 arbiter: one fetch then one store, row k = cycle k.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("v%0d_mem_en", k), 32'(mem_en1), 32'(tv[k].en));
      chk($sformatf("v%0d_busy", k), 32'(busy1), 32'(tv[k].bz));
      chk($sformatf("v%0d_grant_ls", k), 32'(grant_ls1), 32'(tv[k].gl));
      chk($sformatf("v%0d_if_ack", k), 32'(if_ack1), 32'(tv[k].ik));
      chk($sformatf("v%0d_ls_ack", k), 32'(ls_ack1), 32'(tv[k].lk));
      if (tv[k].ik) chk($sformatf("v%0d_if_rdata", k), if_rdata1, tv[k].ird);
      if (tv[k].lk) chk($sformatf("v%0d_ls_rdata", k), ls_rdata1, tv[k].lrd);
      if (tv[k].en) begin
        chk($sformatf("v%0d_mem_we", k), 32'(mem_we1), 32'(tv[k].we));
        chk($sformatf("v%0d_mem_wstrb", k), 32'(mem_wstrb1), 32'(tv[k].st));
        chk($sformatf("v%0d_mem_addr", k), mem_addr1, tv[k].ma);
        if (tv[k].we) chk($sformatf("v%0d_mem_wdata", k), mem_wdata1, tv[k].md);
      end
      if_req = tv[k].ir; if_addr = tv[k].ia; ls_req = tv[k].lr; ls_we = tv[k].lw;
      ls_wstrb = tv[k].ls; ls_addr = tv[k].la; ls_wdata = tv[k].ld; rd_word = tv[k].rw;
      @(negedge clock);
    end

    // Both requesting continuously from reset: IF first, then strict alternation every 4 cycles.
    do_reset();
    if_req = 1'b1; if_addr = 32'h40; ls_req = 1'b1; ls_addr = 32'h80; rd_word = 32'h5555_AAAA;
    n = 0; prev = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      if (if_ack1 || ls_ack1) begin
        chk("alt_owner", 32'(ls_ack1), 32'(n % 2));
        chk("alt_grant_ls", 32'(grant_ls1), 32'(n % 2));
        chk("alt_both_ack", 32'(if_ack1 & ls_ack1), 32'h0);
        chk("alt_gap", 32'(c - prev), (n == 0) ? 32'd3 : 32'd4);
        prev = c;
        n++;
      end
      @(negedge clock);
    end
    chk("alt_count", 32'(n), 32'd8);

    // Same requester back-to-back with if_req held through ACK.
    do_reset();
    if_req = 1'b1; if_addr = 32'hC; rd_word = 32'h1111_2222;
    e1 = -1; e2 = -1; na = 0; cons = 0; pk = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (mem_en1) begin
        if (e1 < 0) e1 = c;
        else if (e2 < 0) e2 = c;
      end
      if (if_ack1) na++;
      if (if_ack1 && pk) cons++;
      pk = if_ack1;
      @(negedge clock);
    end
    chk("b2b_first_en", 32'(e1), 32'd1);
    chk("b2b_en_gap", 32'(e2 - e1), 32'd4);
    chk("b2b_ack_consec", 32'(cons), 32'd0);
    chk("b2b_ack_count", 32'(na), 32'd5);

    // Latency-3 load: issue in cycle 1, ack in cycle 5, busy across 1..5.
    do_reset();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; rd_word = 32'h1234_5678;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("l3_c%0d_mem_en", c), 32'(mem_en3), 32'(c == 1));
      chk($sformatf("l3_c%0d_busy", c), 32'(busy3), 32'(c >= 1 && c <= 5));
      chk($sformatf("l3_c%0d_ls_ack", c), 32'(ls_ack3), 32'(c == 5));
      chk($sformatf("l3_c%0d_if_ack", c), 32'(if_ack3), 32'h0);
      if (c == 1) begin
        chk("l3_mem_addr", mem_addr3, 32'h200);
        chk("l3_mem_we", 32'(mem_we3), 32'h0);
        chk("l3_mem_wstrb", 32'(mem_wstrb3), 32'h0);
      end
      if (c == 5) chk("l3_ls_rdata", ls_rdata3, 32'h1234_5678);
      ls_req = (c < 5);
      @(negedge clock);
    end

    // Reset in the middle of a latency-3 WAIT: outputs clear at once, the ack never appears.
    do_reset();
    ls_req = 1'b1; ls_addr = 32'h300; rd_word = 32'h7777_7777;
    repeat (3) @(negedge clock);
    chk("rst_pre_busy", 32'(busy3), 32'h1);
    chk("rst_pre_grant_ls", 32'(grant_ls3), 32'h1);
    reset = 1'b1;
    ls_req = 1'b0;
    #1;
    chk("rst_busy", 32'(busy3), 32'h0);
    chk("rst_grant_ls", 32'(grant_ls3), 32'h0);
    chk("rst_mem_en", 32'(mem_en3), 32'h0);
    chk("rst_ls_ack", 32'(ls_ack3), 32'h0);
    chk("rst_mem_addr", mem_addr3, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    na = 0;
    for (int c = 0; c < 8; c++) begin
      if (if_ack3 || ls_ack3 || busy3) na++;
      @(negedge clock);
    end
    chk("rst_no_activity", 32'(na), 32'h0);
    if_req = 1'b1; if_addr = 32'h8; ls_req = 1'b1; ls_addr = 32'h400; rd_word = 32'h0BAD_F00D;
    e1 = -1;
    for (int c = 0; c < 12 && e1 < 0; c++) begin
      if (if_ack3 || ls_ack3) begin
        e1 = c;
        chk("rst_after_owner_if", 32'(if_ack3), 32'h1);
        chk("rst_after_if_rdata", if_rdata3, 32'h0BAD_F00D);
      end
      @(negedge clock);
    end
    chk("rst_after_latency", 32'(e1), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
Shares one single-port unified memory between the CPU's instruction-fetch port (IF) and load/store port (LS). One transaction is outstanding at a time. Simultaneous requests are resolved round-robin. Requesters stall until their ack pulse. Sits between top_mod's fetch/LSU paths and the memory model, enabling the move from split to unified memory.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; multiple of 8
MEM_LATENCY, 1, cycles from mem_en to mem_rdata valid; legal range 1..15

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held high with if_addr stable until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle pulse: fetch complete
if_rdata  out  DATA_W  fetched word, valid only while if_ack=1
ls_req  in  1  load/store request; held with its fields stable until ls_ack
ls_we  in  1  1 = store, 0 = load
ls_wstrb  in  DATA_W/8  byte enables for store
ls_addr  in  ADDR_W  data address (passed through, no alignment check)
ls_wdata  in  DATA_W  store data
ls_ack  out  1  one-cycle pulse: load/store complete
ls_rdata  out  DATA_W  load data while ls_ack=1; 0 for stores
mem_en  out  1  one-cycle issue strobe to memory
mem_we  out  1  write enable, valid with mem_en
mem_wstrb  out  DATA_W/8  byte enables; all-zero for reads
mem_addr  out  ADDR_W  address, valid with mem_en
mem_wdata  out  DATA_W  write data, valid with mem_en
mem_rdata  in  DATA_W  read data, valid exactly MEM_LATENCY cycles after the mem_en cycle
busy  out  1  1 in any state other than IDLE
grant_ls  out  1  owner of the current/last transaction (1 = LS, 0 = IF)

Behaviour:
- Reset (async, immediate): state=IDLE; mem_en, mem_we, if_ack, ls_ack, busy = 0; mem_wstrb/addr/wdata = 0; if_rdata, ls_rdata = 0; wait counter = 0; last-grant = LS, so the first tie goes to IF.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any req is high at the clock edge, choose the winner and go to ISSUE.
  - Only one requester: it wins.
  - Both requesters: the one not granted last wins; update last-grant.
  - Latch the winner's addr, we, wstrb, wdata.
- ISSUE: lasts 1 cycle with mem_en=1 and the latched fields on mem_*.
  - IF always drives we=0, wstrb=0.
  - Load counter with MEM_LATENCY; go to WAIT.
- WAIT: decrement the counter each cycle.
  - The cycle in which mem_rdata is valid is ISSUE cycle + MEM_LATENCY; capture it at the end of that cycle; go to ACK.
  - When MEM_LATENCY=1, WAIT lasts exactly 1 cycle.
- ACK: 1 cycle. The winner's ack=1 and its rdata = captured word (0 for a store). The other ack stays 0. Go to IDLE.
- Latency: req first high in IDLE cycle 0 → mem_en in cycle 1 → ack in cycle 2+MEM_LATENCY.
  - Per-transaction occupancy is 3+MEM_LATENCY cycles.
  - Back-to-back from the same requester is allowed.
- Requests are ignored outside IDLE. A req still high during its own ACK cycle is not a new request. The requester must keep or present req in the cycle after ACK for a new transaction.
- Requests sampled in ISSUE/WAIT/ACK are held off, not lost, because the protocol requires req to be held.
- Fairness: with both requesting continuously, grants strictly alternate. No requester waits more than one foreign transaction.
- A requester dropping req before its ack is a protocol violation. The transaction still completes and the ack is still pulsed.
- Reset mid-transaction: any ack is lost and memory may have seen mem_en. Requesters are reset together with the arbiter.
- Counter is 4 bits and never wraps; MEM_LATENCY outside 1..15 is rejected at elaboration.

Decomposition:
- Package rv_mem_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, ACK)
  - grant constants GNT_IF=0, GNT_LS=1
  - LAT_CNT_W=4
- Sub-module rr_arb2: 2-way round-robin picker, combinational on the two reqs plus the last-grant register. The FSM, latches and counter stay in rv_mem_arbiter.

Test Plan:
- MEM_LATENCY=1, reset released, if_req=1, if_addr=0x0000_0004, mem_rdata=0x0010_0093 → mem_en only in cycle 1 with addr 0x4, we=0; if_ack=1 and if_rdata=0x0010_0093 only in cycle 3; ls_ack stays 0.
- Both req high immediately after reset → IF served first (grant_ls=0), then LS; ls_ack arrives 4 cycles after if_ack; continuous requests alternate IF,LS,IF,LS over 8 transactions.
- Store ls_we=1, ls_wstrb=4'b0011, ls_addr=0x100, ls_wdata=0xDEAD_BEEF → one mem_en cycle with we=1, wstrb=0011, wdata=0xDEADBEEF; ls_ack pulse with ls_rdata=0.
- MEM_LATENCY=3, load at 0x200 with memory returning 0x1234_5678 → mem_en in cycle 1; ls_ack with ls_rdata=0x12345678 in cycle 5; busy=1 for cycles 1..5.
- Reset asserted during WAIT → all outputs 0 immediately (mid-cycle); no ack after release; next if_req served with normal latency and IF priority.
- Same requester back-to-back (if_req held across ACK) → second mem_en exactly 4 cycles after the first (MEM_LATENCY=1); if_ack never high two consecutive cycles.
